// File: rtl/counter_seq_pkg.sv
// Shared definitions for the 8-entry non-sequential counter sequencer:
// the code table the counter walks through and the controller state type.
package counter_seq_pkg;

  localparam int SEQ_LEN = 8;

  localparam logic [3:0] SEQ_CODE [0:SEQ_LEN-1] = '{
    4'b0001, 4'b0011, 4'b0111, 4'b1010,
    4'b1100, 4'b1111, 4'b0010, 4'b1001
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AUTO  = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  function automatic logic [3:0] seq_code(input logic [2:0] idx);
    return SEQ_CODE[idx];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// registered one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta_q;
  logic          sync_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] stable_cnt_q;

  // The count holds how many mismatching cycles have already been seen; the
  // level flips on the edge after a full window of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q  <= 1'b0;
      sync_q       <= 1'b0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      stable_cnt_q <= '0;
    end else begin
      sync_meta_q <= raw;
      sync_q      <= sync_meta_q;
      rise_q      <= 1'b0;
      if (sync_q == level_q) begin
        stable_cnt_q <= '0;
      end else if (stable_cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        level_q      <= sync_q;
        rise_q       <= sync_q;
        stable_cnt_q <= '0;
      end else begin
        stable_cnt_q <= stable_cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/counter_step_ctrl.sv
// Step sequencer for the 8-code counter: manual/auto stepping, pause on the
// button, sequence tracking with wrap flag, and a sticky value-check fault.
//
//   state | meaning
//   IDLE  | manual mode, one step per debounced press
//   AUTO  | periodic step every AUTO_PERIOD cycles, press pauses
//   PAUSE | auto timer frozen, no steps, press resumes
module counter_step_ctrl
  import counter_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       mode_auto,
  input  logic [3:0] value_in,
  output logic       step,
  output logic       wrap,
  output logic [2:0] seq_idx,
  output logic       paused,
  output logic       fault
);

  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

  logic          press;
  logic          unused_btn_level;
  logic          mode_meta_q;
  logic          mode_sync_q;
  ctrl_state_t   state_q;
  ctrl_state_t   state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          fire;
  logic          step_q;
  logic          wrap_q;
  logic [2:0]    idx_q;
  logic          paused_q;
  logic          check_q;
  logic          fault_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn),
    .level(unused_btn_level),
    .rise (press)
  );

  // Leaving auto mode always wins over a same-cycle expiry or press.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        fire = press;
        if (mode_sync_q) begin
          state_d = AUTO;
          timer_d = '0;
        end
      end
      AUTO: begin
        if (!mode_sync_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            fire    = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
          if (press) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!mode_sync_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (press) begin
          state_d = AUTO;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      idx_q       <= 3'd0;
      paused_q    <= 1'b0;
      check_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      mode_meta_q <= mode_auto;
      mode_sync_q <= mode_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      step_q      <= fire;
      wrap_q      <= fire && (idx_q == 3'd7);
      if (fire) idx_q <= idx_q + 3'd1;
      paused_q    <= (state_d == PAUSE);
      // The counter advances on the step edge, so its new code is valid one cycle later.
      check_q     <= step_q;
      if (check_q && (value_in != seq_code(idx_q))) fault_q <= 1'b1;
    end
  end

  assign step    = step_q;
  assign wrap    = wrap_q;
  assign seq_idx = idx_q;
  assign paused  = paused_q;
  assign fault   = fault_q;

endmodule
